// File: rtl/stream_joiner_arb_pkg.sv
// Shared definitions for the stream joiner arbiter.
// Contents: default word width, the stream terminator token, the index of the
// control-token flag bit, and the arbiter state encoding.
package stream_joiner_arb_pkg;

    localparam int DATA_W   = 17;
    localparam int CTRL_BIT = 16;

    // A stream lane ends when this exact word is transferred. Other words with
    // the control bit set are ordinary traffic as far as the arbiter is concerned.
    localparam logic [16:0] DONE_TOKEN = 17'h10100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/sparse_lane_gate.sv
// One lane (coordinate or position) of the stream joiner.
// Selects the granted requester's word onto the shared output, detects the
// stream terminator, and holds the lane's done flag. Once the flag is set the
// lane stalls in both directions until the arbiter releases the grant.
// Ports:
//   clk, rst_n, flush   - clock, synchronous active-low reset, synchronous clear
//   en                  - state update enable (clock enable and tile enable)
//   active              - a grant is held and the tile is enabled
//   grant               - granted requester (0 or 1)
//   clear_flag          - arbiter release cycle: drop the done flag
//   data0/valid0/ready0 - requester 0 side of this lane
//   data1/valid1/ready1 - requester 1 side of this lane
//   out_data/out_valid/out_ready - shared downstream side of this lane
//   done                - lane has transferred its terminator
//
// Handshake: a word moves when valid and ready are both high at a rising
// clock edge; valid never depends on ready on the upstream side, and the
// requester readies depend combinationally on out_ready (zero-latency pass).
module sparse_lane_gate #(
    parameter int DATA_W = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              en,
    input  logic              active,
    input  logic              grant,
    input  logic              clear_flag,
    input  logic [DATA_W-1:0] data0,
    input  logic              valid0,
    output logic              ready0,
    input  logic [DATA_W-1:0] data1,
    input  logic              valid1,
    output logic              ready1,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              done
);
    import stream_joiner_arb_pkg::*;

    localparam logic [DATA_W-1:0] DONE_W = DATA_W'(DONE_TOKEN);

    logic              done_q;
    logic [DATA_W-1:0] sel_data;
    logic              sel_valid;
    logic              xfer;

    always_comb begin
        sel_data  = grant ? data1  : data0;
        sel_valid = grant ? valid1 : valid0;
    end

    // Both directions are masked by done_q so a finished lane can neither emit
    // nor consume while the other lane catches up.
    assign out_data  = sel_data;
    assign out_valid = active & ~done_q & sel_valid;
    assign ready0    = active & ~grant & out_ready & ~done_q;
    assign ready1    = active &  grant & out_ready & ~done_q;
    assign xfer      = out_valid & out_ready;
    assign done      = done_q;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            done_q <= 1'b0;
        end else if (en) begin
            if (clear_flag) begin
                done_q <= 1'b0;
            end else if (xfer && (sel_data == DONE_W)) begin
                done_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_joiner_arb.sv
// Shares one intersect unit between two requesters, one whole stream at a
// time. A stream is a coordinate lane and a position lane, each terminated by
// DONE_TOKEN. The grant is released only after both lanes have finished, in a
// dedicated release cycle in which no word moves; the next grant then goes
// round-robin to the other requester if it is waiting.
// Ports:
//   clk, rst_n, clk_en, flush, tile_en - clocking and control
//   req{0,1}_coord[_valid/_ready]      - requester coordinate streams
//   req{0,1}_pos[_valid/_ready]        - requester position streams
//   coord_out[_valid/_ready], pos_out[_valid/_ready] - shared unit side
//   grant_id, busy                     - current / last grant, grant held
//   stream_cnt_0, stream_cnt_1         - completed streams, wrapping
//   dbg_state                          - arbiter state encoding (arb_state_t)
//
// Handshake: valid/ready, a word transfers on a rising edge where both are
// high; lanes pass through combinationally with zero latency.
module stream_joiner_arb #(
    parameter int DATA_W = 17,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic              flush,
    input  logic              tile_en,
    input  logic [DATA_W-1:0] req0_coord,
    input  logic              req0_coord_valid,
    output logic              req0_coord_ready,
    input  logic [DATA_W-1:0] req1_coord,
    input  logic              req1_coord_valid,
    output logic              req1_coord_ready,
    input  logic [DATA_W-1:0] req0_pos,
    input  logic              req0_pos_valid,
    output logic              req0_pos_ready,
    input  logic [DATA_W-1:0] req1_pos,
    input  logic              req1_pos_valid,
    output logic              req1_pos_ready,
    output logic [DATA_W-1:0] coord_out,
    output logic              coord_out_valid,
    input  logic              coord_out_ready,
    output logic [DATA_W-1:0] pos_out,
    output logic              pos_out_valid,
    input  logic              pos_out_ready,
    output logic              grant_id,
    output logic              busy,
    output logic [CNT_W-1:0]  stream_cnt_0,
    output logic [CNT_W-1:0]  stream_cnt_1,
    output logic [1:0]        dbg_state
);
    import stream_joiner_arb_pkg::*;

    arb_state_t       state_q;
    arb_state_t       state_d;
    logic             last_grant_q;
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;

    logic en;
    logic active;
    logic grant;
    logic any0;
    logic any1;
    logic coord_done;
    logic pos_done;
    logic rel;

    assign en     = clk_en & tile_en;
    assign active = tile_en & (state_q != IDLE);
    assign grant  = (state_q == GRANT1);
    assign any0   = req0_coord_valid | req0_pos_valid;
    assign any1   = req1_coord_valid | req1_pos_valid;
    // Release cycle: both lanes already finished, so both are stalled and no
    // word can move while the grant is handed over.
    assign rel    = (state_q != IDLE) & coord_done & pos_done;

    sparse_lane_gate #(.DATA_W(DATA_W)) coord_lane (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .en         (en),
        .active     (active),
        .grant      (grant),
        .clear_flag (rel),
        .data0      (req0_coord),
        .valid0     (req0_coord_valid),
        .ready0     (req0_coord_ready),
        .data1      (req1_coord),
        .valid1     (req1_coord_valid),
        .ready1     (req1_coord_ready),
        .out_data   (coord_out),
        .out_valid  (coord_out_valid),
        .out_ready  (coord_out_ready),
        .done       (coord_done)
    );

    sparse_lane_gate #(.DATA_W(DATA_W)) pos_lane (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .en         (en),
        .active     (active),
        .grant      (grant),
        .clear_flag (rel),
        .data0      (req0_pos),
        .valid0     (req0_pos_valid),
        .ready0     (req0_pos_ready),
        .data1      (req1_pos),
        .valid1     (req1_pos_valid),
        .ready1     (req1_pos_ready),
        .out_data   (pos_out),
        .out_valid  (pos_out_valid),
        .out_ready  (pos_out_ready),
        .done       (pos_done)
    );

    // State register. Reset and flush win over clk_en and tile_en.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state_q <= IDLE;
        end else if (en) begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any0 && any1) begin
                    state_d = last_grant_q ? GRANT0 : GRANT1;
                end else if (any0) begin
                    state_d = GRANT0;
                end else if (any1) begin
                    state_d = GRANT1;
                end
            end
            GRANT0: begin
                if (rel) begin
                    if (any1)      state_d = GRANT1;
                    else if (any0) state_d = GRANT0;
                    else           state_d = IDLE;
                end
            end
            GRANT1: begin
                if (rel) begin
                    if (any0)      state_d = GRANT0;
                    else if (any1) state_d = GRANT1;
                    else           state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Round-robin pointer and completed-stream counters. last_grant resets to
    // 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            last_grant_q <= 1'b1;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else if (en && rel) begin
            last_grant_q <= grant;
            if (grant) cnt1_q <= cnt1_q + CNT_W'(1);
            else       cnt0_q <= cnt0_q + CNT_W'(1);
        end
    end

    // Output logic.
    always_comb begin
        busy         = (state_q != IDLE);
        grant_id     = (state_q == IDLE) ? last_grant_q : grant;
        stream_cnt_0 = cnt0_q;
        stream_cnt_1 = cnt1_q;
        dbg_state    = state_q;
    end

endmodule

// File: tb/tb_stream_joiner_arb.sv
module tb_stream_joiner_arb;

    localparam int DATA_W = 17;
    localparam int CNT_W  = 8;
    localparam logic [DATA_W-1:0] DONE = 17'h10100;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n   = 1'b0;
    logic clk_en  = 1'b1;
    logic flush   = 1'b0;
    logic tile_en = 1'b1;

    logic [DATA_W-1:0] req0_coord, req1_coord, req0_pos, req1_pos;
    logic req0_coord_valid = 1'b0, req1_coord_valid = 1'b0;
    logic req0_pos_valid = 1'b0, req1_pos_valid = 1'b0;
    logic req0_coord_ready, req1_coord_ready, req0_pos_ready, req1_pos_ready;
    logic [DATA_W-1:0] coord_out, pos_out;
    logic coord_out_valid, pos_out_valid;
    logic coord_out_ready = 1'b1, pos_out_ready = 1'b1;
    logic grant_id, busy;
    logic [CNT_W-1:0] stream_cnt_0, stream_cnt_1;
    logic [1:0] dbg_state;

    stream_joiner_arb #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .clk_en           (clk_en),
        .flush            (flush),
        .tile_en          (tile_en),
        .req0_coord       (req0_coord),
        .req0_coord_valid (req0_coord_valid),
        .req0_coord_ready (req0_coord_ready),
        .req1_coord       (req1_coord),
        .req1_coord_valid (req1_coord_valid),
        .req1_coord_ready (req1_coord_ready),
        .req0_pos         (req0_pos),
        .req0_pos_valid   (req0_pos_valid),
        .req0_pos_ready   (req0_pos_ready),
        .req1_pos         (req1_pos),
        .req1_pos_valid   (req1_pos_valid),
        .req1_pos_ready   (req1_pos_ready),
        .coord_out        (coord_out),
        .coord_out_valid  (coord_out_valid),
        .coord_out_ready  (coord_out_ready),
        .pos_out          (pos_out),
        .pos_out_valid    (pos_out_valid),
        .pos_out_ready    (pos_out_ready),
        .grant_id         (grant_id),
        .busy             (busy),
        .stream_cnt_0     (stream_cnt_0),
        .stream_cnt_1     (stream_cnt_1),
        .dbg_state        (dbg_state)
    );

    // ---------------- sources, monitor, scoreboard state ----------------
    logic [DATA_W-1:0] s0c[$], s0p[$], s1c[$], s1p[$];
    bit f0c, f0p, f1c, f1p;
    logic [DATA_W-1:0] got_c[$], got_p[$];
    int got_c_cyc[$], got_p_cyc[$];
    logic [DATA_W-1:0] exp_c[$], exp_p[$];
    int cyc = 0;
    int busy_cycles = 0;
    int cvalid_cycles = 0;
    bit rand_mode = 1'b0;
    bit ready_fix = 1'b1;

    int compared = 0;
    int failed = 0;

    // Inputs change on the falling edge; handshakes are sampled 1ns later,
    // which is what the next rising edge will see.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (f0c && s0c.size() > 0) s0c.delete(0);
        if (f0p && s0p.size() > 0) s0p.delete(0);
        if (f1c && s1c.size() > 0) s1c.delete(0);
        if (f1p && s1p.size() > 0) s1p.delete(0);
        req0_coord_valid = (s0c.size() > 0);
        req0_coord       = (s0c.size() > 0) ? s0c[0] : '0;
        req0_pos_valid   = (s0p.size() > 0);
        req0_pos         = (s0p.size() > 0) ? s0p[0] : '0;
        req1_coord_valid = (s1c.size() > 0);
        req1_coord       = (s1c.size() > 0) ? s1c[0] : '0;
        req1_pos_valid   = (s1p.size() > 0);
        req1_pos         = (s1p.size() > 0) ? s1p[0] : '0;
        coord_out_ready  = rand_mode ? 1'($urandom_range(0, 1)) : ready_fix;
        pos_out_ready    = rand_mode ? 1'($urandom_range(0, 1)) : ready_fix;
        #1;
        if (busy) busy_cycles = busy_cycles + 1;
        if (coord_out_valid) cvalid_cycles = cvalid_cycles + 1;
        f0c = req0_coord_valid & req0_coord_ready;
        f0p = req0_pos_valid & req0_pos_ready;
        f1c = req1_coord_valid & req1_coord_ready;
        f1p = req1_pos_valid & req1_pos_ready;
        if (coord_out_valid && coord_out_ready) begin
            got_c.push_back(coord_out);
            got_c_cyc.push_back(cyc);
        end
        if (pos_out_valid && pos_out_ready) begin
            got_p.push_back(pos_out);
            got_p_cyc.push_back(cyc);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_sources();
        s0c.delete(); s0p.delete(); s1c.delete(); s1p.delete();
        f0c = 0; f0p = 0; f1c = 0; f1p = 0;
    endtask

    task automatic clear_capture();
        got_c.delete(); got_p.delete(); got_c_cyc.delete(); got_p_cyc.delete();
        busy_cycles = 0;
        cvalid_cycles = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_sources();
        step(2);
        rst_n = 1'b1;
        clear_capture();
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step(1);
            if (s0c.size() == 0 && s0p.size() == 0 && s1c.size() == 0 &&
                s1p.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        s0c.push_back(17'h00001);
        s0p.push_back(17'h00002);
        rst_n = 1'b0;
        step(3);
        compared++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy got %b want 0", busy); end
        compared++; if (coord_out_valid !== 1'b0) begin failed++; $display("FAIL reset_coord_valid got %b want 0", coord_out_valid); end
        compared++; if (pos_out_valid !== 1'b0) begin failed++; $display("FAIL reset_pos_valid got %b want 0", pos_out_valid); end
        compared++; if (req0_coord_ready !== 1'b0) begin failed++; $display("FAIL reset_req0_ready got %b want 0", req0_coord_ready); end
        compared++; if (stream_cnt_0 !== 8'd0) begin failed++; $display("FAIL reset_cnt0 got %0d want 0", stream_cnt_0); end
        compared++; if (stream_cnt_1 !== 8'd0) begin failed++; $display("FAIL reset_cnt1 got %0d want 0", stream_cnt_1); end
        compared++; if (grant_id !== 1'b1) begin failed++; $display("FAIL reset_grant_id got %b want 1", grant_id); end
        compared++; if (dbg_state !== 2'd0) begin failed++; $display("FAIL reset_state got %0d want 0", dbg_state); end
        // Reset applied mid-stream: the stream is abandoned at once.
        rst_n = 1'b1;
        s0c.push_back(17'h00003);
        s0c.push_back(DONE);
        step(2);
        compared++; if (busy !== 1'b1) begin failed++; $display("FAIL midreset_pre_busy got %b want 1", busy); end
        rst_n = 1'b0;
        step(1);
        compared++; if (busy !== 1'b0) begin failed++; $display("FAIL midreset_busy got %b want 0", busy); end
        compared++; if (coord_out_valid !== 1'b0 || pos_out_valid !== 1'b0) begin
            failed++; $display("FAIL midreset_valids got %b%b want 00", coord_out_valid, pos_out_valid);
        end
        clear_sources();
        step(1);
        rst_n = 1'b1;
        clear_capture();
    endtask

    task automatic test_single_stream();
        bit ok;
        do_reset();
        exp_c = '{17'h00003, 17'h00007, 17'h10000, DONE};
        exp_p = '{17'h00000, 17'h00001, 17'h10000, DONE};
        s0c = exp_c;
        s0p = exp_p;
        wait_done(40, ok);
        compared++; if (!ok) begin failed++; $display("FAIL single_timeout busy %b want idle", busy); end
        compared++; if (got_c.size() != 4 || got_p.size() != 4) begin
            failed++; $display("FAIL single_count got %0d/%0d want 4/4", got_c.size(), got_p.size());
        end
        for (int i = 0; i < 4; i++) begin
            compared++; if (got_c[i] !== exp_c[i]) begin failed++; $display("FAIL single_coord[%0d] got %h want %h", i, got_c[i], exp_c[i]); end
            compared++; if (got_p[i] !== exp_p[i]) begin failed++; $display("FAIL single_pos[%0d] got %h want %h", i, got_p[i], exp_p[i]); end
        end
        compared++; if (stream_cnt_0 !== 8'd1) begin failed++; $display("FAIL single_cnt0 got %0d want 1", stream_cnt_0); end
        compared++; if (stream_cnt_1 !== 8'd0) begin failed++; $display("FAIL single_cnt1 got %0d want 0", stream_cnt_1); end
        compared++; if (dbg_state !== 2'd0) begin failed++; $display("FAIL single_state got %0d want 0", dbg_state); end
        compared++; if (grant_id !== 1'b0) begin failed++; $display("FAIL single_grant_id got %b want 0", grant_id); end
    endtask

    task automatic test_tie();
        bit ok;
        do_reset();
        s0c = '{17'h00001, DONE};
        s0p = '{17'h00002, DONE};
        s1c = '{17'h00003, DONE};
        s1p = '{17'h00004, DONE};
        exp_c = '{17'h00001, DONE, 17'h00003, DONE};
        exp_p = '{17'h00002, DONE, 17'h00004, DONE};
        wait_done(40, ok);
        compared++; if (!ok) begin failed++; $display("FAIL tie_timeout busy %b want idle", busy); end
        compared++; if (got_c.size() != 4 || got_p.size() != 4) begin
            failed++; $display("FAIL tie_count got %0d/%0d want 4/4", got_c.size(), got_p.size());
        end
        for (int i = 0; i < 4; i++) begin
            compared++; if (got_c[i] !== exp_c[i]) begin failed++; $display("FAIL tie_coord[%0d] got %h want %h", i, got_c[i], exp_c[i]); end
            compared++; if (got_p[i] !== exp_p[i]) begin failed++; $display("FAIL tie_pos[%0d] got %h want %h", i, got_p[i], exp_p[i]); end
        end
        // One idle release cycle between req0's done and req1's first word.
        compared++; if (got_c_cyc[2] - got_c_cyc[1] != 2) begin
            failed++; $display("FAIL tie_switch_gap got %0d want 2", got_c_cyc[2] - got_c_cyc[1]);
        end
        compared++; if (stream_cnt_0 !== 8'd1) begin failed++; $display("FAIL tie_cnt0 got %0d want 1", stream_cnt_0); end
        compared++; if (stream_cnt_1 !== 8'd1) begin failed++; $display("FAIL tie_cnt1 got %0d want 1", stream_cnt_1); end
        compared++; if (grant_id !== 1'b1) begin failed++; $display("FAIL tie_grant_id got %b want 1", grant_id); end
    endtask

    task automatic test_skew();
        bit ok;
        do_reset();
        exp_c = '{17'h00005, DONE};
        exp_p = '{17'h00001, 17'h00002, 17'h00003, 17'h00004, DONE};
        s0c = exp_c;
        s0p = exp_p;
        wait_done(40, ok);
        compared++; if (!ok) begin failed++; $display("FAIL skew_timeout busy %b want idle", busy); end
        compared++; if (got_c.size() != 2 || got_p.size() != 5) begin
            failed++; $display("FAIL skew_count got %0d/%0d want 2/5", got_c.size(), got_p.size());
        end
        for (int i = 0; i < 2; i++) begin
            compared++; if (got_c[i] !== exp_c[i]) begin failed++; $display("FAIL skew_coord[%0d] got %h want %h", i, got_c[i], exp_c[i]); end
        end
        for (int i = 0; i < 5; i++) begin
            compared++; if (got_p[i] !== exp_p[i]) begin failed++; $display("FAIL skew_pos[%0d] got %h want %h", i, got_p[i], exp_p[i]); end
        end
        compared++; if (got_p_cyc[4] - got_c_cyc[1] != 3) begin
            failed++; $display("FAIL skew_done_gap got %0d want 3", got_p_cyc[4] - got_c_cyc[1]);
        end
        compared++; if (cvalid_cycles != 2) begin failed++; $display("FAIL skew_coord_valid_cycles got %0d want 2", cvalid_cycles); end
        compared++; if (busy_cycles != 6) begin failed++; $display("FAIL skew_busy_cycles got %0d want 6", busy_cycles); end
        compared++; if (stream_cnt_0 !== 8'd1) begin failed++; $display("FAIL skew_cnt0 got %0d want 1", stream_cnt_0); end
    endtask

    task automatic test_random_ready();
        bit ok;
        do_reset();
        rand_mode = 1'b1;
        s0c = '{17'h00011, 17'h00012, DONE, 17'h00013, DONE};
        s0p = '{17'h00021, DONE, 17'h00022, 17'h00023, DONE};
        s1c = '{17'h00031, DONE, 17'h00032, 17'h00033, DONE};
        s1p = '{17'h00041, 17'h00042, DONE, 17'h00043, DONE};
        exp_c = '{17'h00011, 17'h00012, DONE, 17'h00031, DONE,
                  17'h00013, DONE, 17'h00032, 17'h00033, DONE};
        exp_p = '{17'h00021, DONE, 17'h00041, 17'h00042, DONE,
                  17'h00022, 17'h00023, DONE, 17'h00043, DONE};
        wait_done(400, ok);
        rand_mode = 1'b0;
        compared++; if (!ok) begin failed++; $display("FAIL rand_timeout busy %b want idle", busy); end
        compared++; if (got_c.size() != 10 || got_p.size() != 10) begin
            failed++; $display("FAIL rand_count got %0d/%0d want 10/10", got_c.size(), got_p.size());
        end
        for (int i = 0; i < 10; i++) begin
            compared++; if (got_c[i] !== exp_c[i]) begin failed++; $display("FAIL rand_coord[%0d] got %h want %h", i, got_c[i], exp_c[i]); end
            compared++; if (got_p[i] !== exp_p[i]) begin failed++; $display("FAIL rand_pos[%0d] got %h want %h", i, got_p[i], exp_p[i]); end
        end
        compared++; if (stream_cnt_0 !== 8'd2) begin failed++; $display("FAIL rand_cnt0 got %0d want 2", stream_cnt_0); end
        compared++; if (stream_cnt_1 !== 8'd2) begin failed++; $display("FAIL rand_cnt1 got %0d want 2", stream_cnt_1); end
    endtask

    task automatic test_flush();
        bit ok;
        do_reset();
        s0c = '{17'h00071, DONE};
        s0p = '{17'h00072, DONE};
        wait_done(40, ok);
        compared++; if (!ok || stream_cnt_0 !== 8'd1) begin
            failed++; $display("FAIL flush_pre_cnt0 got %0d want 1", stream_cnt_0);
        end
        clear_capture();
        s1c = '{17'h00051, 17'h00052, 17'h00053, DONE};
        s1p = '{17'h00061, 17'h00062, 17'h00063, DONE};
        step(3);
        compared++; if (busy !== 1'b1 || grant_id !== 1'b1) begin
            failed++; $display("FAIL flush_pre_grant got busy %b id %b want 1 1", busy, grant_id);
        end
        flush = 1'b1;
        step(1);
        compared++; if (busy !== 1'b0) begin failed++; $display("FAIL flush_busy got %b want 0", busy); end
        compared++; if (coord_out_valid !== 1'b0 || pos_out_valid !== 1'b0) begin
            failed++; $display("FAIL flush_valids got %b%b want 00", coord_out_valid, pos_out_valid);
        end
        compared++; if (req1_coord_ready !== 1'b0 || req1_pos_ready !== 1'b0) begin
            failed++; $display("FAIL flush_readies got %b%b want 00", req1_coord_ready, req1_pos_ready);
        end
        compared++; if (stream_cnt_0 !== 8'd0 || stream_cnt_1 !== 8'd0) begin
            failed++; $display("FAIL flush_cnts got %0d/%0d want 0/0", stream_cnt_0, stream_cnt_1);
        end
        flush = 1'b0;
        clear_sources();
        clear_capture();
        exp_c = '{17'h00081, DONE};
        exp_p = '{17'h00082, DONE};
        s0c = exp_c;
        s0p = exp_p;
        wait_done(40, ok);
        compared++; if (!ok) begin failed++; $display("FAIL flush_after_timeout busy %b want idle", busy); end
        compared++; if (got_c.size() != 2 || got_p.size() != 2) begin
            failed++; $display("FAIL flush_after_count got %0d/%0d want 2/2", got_c.size(), got_p.size());
        end
        for (int i = 0; i < 2; i++) begin
            compared++; if (got_c[i] !== exp_c[i]) begin failed++; $display("FAIL flush_after_coord[%0d] got %h want %h", i, got_c[i], exp_c[i]); end
            compared++; if (got_p[i] !== exp_p[i]) begin failed++; $display("FAIL flush_after_pos[%0d] got %h want %h", i, got_p[i], exp_p[i]); end
        end
        compared++; if (stream_cnt_0 !== 8'd1 || stream_cnt_1 !== 8'd0) begin
            failed++; $display("FAIL flush_after_cnts got %0d/%0d want 1/0", stream_cnt_0, stream_cnt_1);
        end
    endtask

    task automatic test_tile_en();
        bit ok;
        int n_c;
        int n_p;
        int guard;
        do_reset();
        exp_c = '{17'h00001, 17'h00002, 17'h00003, DONE};
        exp_p = '{17'h00004, 17'h00005, 17'h00006, DONE};
        s0c = exp_c;
        s0p = exp_p;
        guard = 0;
        while (got_c.size() < 1 && guard < 20) begin
            step(1);
            guard++;
        end
        compared++; if (got_c.size() < 1) begin failed++; $display("FAIL tile_start got %0d words want 1", got_c.size()); end
        tile_en = 1'b0;
        n_c = got_c.size();
        n_p = got_p.size();
        cvalid_cycles = 0;
        step(5);
        compared++; if (got_c.size() != n_c || got_p.size() != n_p) begin
            failed++; $display("FAIL tile_frozen got %0d/%0d want %0d/%0d", got_c.size(), got_p.size(), n_c, n_p);
        end
        compared++; if (cvalid_cycles != 0) begin failed++; $display("FAIL tile_valid_cycles got %0d want 0", cvalid_cycles); end
        compared++; if (req0_coord_ready !== 1'b0) begin failed++; $display("FAIL tile_ready got %b want 0", req0_coord_ready); end
        compared++; if (dbg_state !== 2'd1) begin failed++; $display("FAIL tile_state got %0d want 1", dbg_state); end
        tile_en = 1'b1;
        wait_done(40, ok);
        compared++; if (!ok) begin failed++; $display("FAIL tile_timeout busy %b want idle", busy); end
        compared++; if (got_c.size() != 4 || got_p.size() != 4) begin
            failed++; $display("FAIL tile_count got %0d/%0d want 4/4", got_c.size(), got_p.size());
        end
        for (int i = 0; i < 4; i++) begin
            compared++; if (got_c[i] !== exp_c[i]) begin failed++; $display("FAIL tile_coord[%0d] got %h want %h", i, got_c[i], exp_c[i]); end
            compared++; if (got_p[i] !== exp_p[i]) begin failed++; $display("FAIL tile_pos[%0d] got %h want %h", i, got_p[i], exp_p[i]); end
        end
        compared++; if (stream_cnt_0 !== 8'd1) begin failed++; $display("FAIL tile_cnt0 got %0d want 1", stream_cnt_0); end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        test_reset();
        test_single_stream();
        test_tie();
        test_skew();
        test_random_ready();
        test_flush();
        test_tile_en();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d want finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
